down_counter_timer: RTL

//  Loadable countdown timer: the counting-down counterpart to the team's free-running up counter.

---
 rtl/down_timer_pkg.sv | 12 +
 rtl/down_counter_timer_tick_prescaler.sv | 44 ++++
 rtl/down_counter_timer.sv | 102 ++++++++++
 3 files changed

// File: rtl/down_timer_pkg.sv
// Shared types and default sizing for the countdown timer and its prescaler.
package down_timer_pkg;

    localparam int unsigned DEF_WIDTH      = 4;
    localparam int unsigned DEF_PRESCALE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/down_counter_timer_tick_prescaler.sv
// Modulo-(prescale+1) cycle counter producing a one-cycle tick while enabled.
module tick_prescaler
    import down_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    // Wrap is decided by the programmed divider, not by counter overflow.
    assign tick_o = en_i && (cnt_q == prescale_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (tick_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable countdown timer with start/busy/done handshake and optional auto-reload.
//   state | meaning
//   IDLE  | waiting for start; count holds last value
//   RUN   | counting down one step per prescaled tick
module down_counter_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  auto_reload_i,
    input  logic [WIDTH-1:0]      load_val_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [WIDTH-1:0]      count_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  tc_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    timer_state_t     state_q;
    logic [WIDTH-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic             tick;
    logic             start_accept;
    logic             running;

    assign running      = (state_q == RUN);
    assign start_accept = (state_q == IDLE) && start_i;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (start_accept),
        .en_i       (running),
        .prescale_i (prescale_i),
        .tick_o     (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (load_val_i != '0) begin
                            count_q <= load_val_i;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            count_q <= '0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Abort freezes count where it is and suppresses done.
                    if (stop_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (tick) begin
                        if (count_q > ONE) begin
                            count_q <= count_q - ONE;
                        end else begin
                            done_q <= 1'b1;
                            if (auto_reload_i && (load_val_i != '0)) begin
                                count_q <= load_val_i;
                            end else begin
                                count_q <= '0;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count_o = count_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign tc_o    = (count_q == '0);

endmodule
